integral_stream: RTL and testbench

INTEGRAL_STREAM -- requirements
Module: integral_stream

---
 rtl/integral_pkg.sv | 24 ++
 rtl/integral_linebuf.sv | 24 ++
 rtl/integral_stream.sv | 199 +++++++++++++++++++
 tb/tb_integral_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/integral_pkg.sv
// Shared types and elaboration helpers for the streaming integral-image block.
package integral_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Round a frame dimension up to the next multiple of a power-of-two alignment.
  function automatic logic [16:0] round_up(input logic [15:0] v, input int unsigned align);
    logic [16:0] m;
    m = 17'(align - 1);
    return ({1'b0, v} + m) & ~m;
  endfunction

  // Smallest accumulator that cannot overflow on a full-size frame of maximum pixels.
  function automatic int unsigned min_acc_w(input int unsigned pix_w,
                                            input int unsigned max_w,
                                            input int unsigned max_h);
    return pix_w + $clog2(max_w * max_h);
  endfunction

endpackage

// File: rtl/integral_linebuf.sv
// One-row line buffer holding the previous row of integral values.
module integral_linebuf #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // No reset: row 0 masks the read data, so stale contents are never observed.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/integral_stream.sv
// Streaming integral-image generator with ALIGN padding, optional binarisation,
// and a single-entry output register with valid/ready backpressure.
module integral_stream
  import integral_pkg::*;
#(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned MAX_W   = 1024,
  parameter int unsigned MAX_H   = 1024,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PAD_VAL = 255,
  parameter int unsigned ALIGN   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      img_w,
  input  logic [15:0]      img_h,
  input  logic             bin_en,
  input  logic [PIX_W-1:0] thr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int unsigned AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  if (ACC_W < min_acc_w(PIX_W, MAX_W, MAX_H)) begin : g_acc_w_check
    $error("integral_stream: ACC_W too narrow for PIX_W/MAX_W/MAX_H");
  end

  state_t           state_q, state_d;
  logic [16:0]      pw_q, pw_d, ph_q, ph_d;
  logic [15:0]      img_w_q, img_w_d, img_h_q, img_h_d;
  logic             bin_en_q, bin_en_d;
  logic [PIX_W-1:0] thr_q, thr_d;
  logic [15:0]      row_q, row_d, col_q, col_d;
  logic [ACC_W-1:0] rowsum_q, rowsum_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_eol_q, out_eol_d, out_last_q, out_last_d;
  logic             cfg_err_q, cfg_err_d;

  logic [16:0]      pw_new, ph_new;
  logic             cfg_bad, is_pix, at_eol, at_last, can_take, take;
  logic [PIX_W-1:0] pix_raw, pix;
  logic [ACC_W-1:0] rs, lb_rd, lb_term, isum;

  always_comb begin
    pw_new  = round_up(img_w, ALIGN);
    ph_new  = round_up(img_h, ALIGN);
    cfg_bad = (img_w == '0) || (img_h == '0) ||
              (pw_new > 17'(MAX_W)) || (ph_new > 17'(MAX_H));

    is_pix  = (row_q < img_h_q) && (col_q < img_w_q);
    at_eol  = ({1'b0, col_q} == pw_q - 17'd1);
    at_last = at_eol && ({1'b0, row_q} == ph_q - 17'd1);

    // A pending last beat blocks the next slot so the frame ends cleanly.
    can_take = (state_q == ST_RUN) && !(out_valid_q && out_last_q) &&
               (!out_valid_q || out_ready);
    take     = can_take && (!is_pix || in_valid);

    pix_raw = is_pix ? in_data : PIX_W'(PAD_VAL);
    pix     = pix_raw;
    if (bin_en_q) pix = (pix_raw <= thr_q) ? '0 : '1;

    rs      = ((col_q == '0) ? '0 : rowsum_q) + ACC_W'(pix);
    lb_term = (row_q == '0) ? '0 : lb_rd;
    isum    = rs + lb_term;
  end

  always_comb begin
    state_d     = state_q;
    pw_d        = pw_q;
    ph_d        = ph_q;
    img_w_d     = img_w_q;
    img_h_d     = img_h_q;
    bin_en_d    = bin_en_q;
    thr_d       = thr_q;
    row_d       = row_q;
    col_d       = col_q;
    rowsum_d    = rowsum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_eol_d   = out_eol_q;
    out_last_d  = out_last_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            pw_d     = pw_new;
            ph_d     = ph_new;
            img_w_d  = img_w;
            img_h_d  = img_h;
            bin_en_d = bin_en;
            thr_d    = thr;
            row_d    = '0;
            col_d    = '0;
            rowsum_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (out_valid_q && out_last_q && out_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = isum;
      out_eol_d   = at_eol;
      out_last_d  = at_last;
      rowsum_d    = rs;
      if (at_eol) begin
        col_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pw_q        <= '0;
      ph_q        <= '0;
      img_w_q     <= '0;
      img_h_q     <= '0;
      bin_en_q    <= 1'b0;
      thr_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rowsum_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eol_q   <= 1'b0;
      out_last_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      ph_q        <= ph_d;
      img_w_q     <= img_w_d;
      img_h_q     <= img_h_d;
      bin_en_q    <= bin_en_d;
      thr_q       <= thr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rowsum_q    <= rowsum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eol_q   <= out_eol_d;
      out_last_q  <= out_last_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Same-column read is combinational and the write lands at the edge, so read sees I(r-1,c).
  integral_linebuf #(
    .DEPTH (MAX_W),
    .WIDTH (ACC_W),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (take),
    .waddr (col_q[AW-1:0]),
    .wdata (isum),
    .raddr (col_q[AW-1:0]),
    .rdata (lb_rd)
  );

  assign in_ready  = can_take && is_pix;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_integral_stream.sv
// Bench for integral_stream: 2-D prefix-sum reference model, per-beat compare, directed frames.
module tb_integral_stream;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] img_w = '0, img_h = '0;
  logic        bin_en = 1'b0;
  logic [7:0]  thr = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_eol, out_last, busy, done, cfg_err;
  logic [31:0] out_data;

  integral_stream #(
    .PIX_W(8), .MAX_W(1024), .MAX_H(1024), .ACC_W(32), .PAD_VAL(255), .ALIGN(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .img_w(img_w), .img_h(img_h),
    .bin_en(bin_en), .thr(thr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_eol(out_eol), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        eol;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned img[16][16];
  int unsigned ii[16][16];
  logic [31:0] got[16][16];

  int total = 0, bad = 0;
  int cyc = 0, beats = 0, in_hs = 0, done_cnt = 0;
  int first_cyc = 0, last_cyc = 0, done_cyc = 0;
  int br = 0, bc = 0, pw_cur = 8;
  int drv_w = 0, drv_h = 0;
  bit drv_go = 0, rand_ready = 0, abort = 0, stall_prev = 0;
  logic [34:0] stall_snap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    beat_t e;
    if (reset) begin
      if (stall_prev)
        chk("stall_hold", 64'({out_valid, out_data, out_eol, out_last}), 64'(stall_snap));
      if (out_valid && out_ready) begin
        if (beats == 0) first_cyc = cyc;
        beats++;
        chk("exp_avail", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat", 64'({out_data, out_eol, out_last}), 64'({e.data, e.eol, e.last}));
          if (br < 16 && bc < 16) got[br][bc] = out_data;
          bc++;
          if (bc >= pw_cur) begin
            bc = 0;
            br++;
          end
        end
        if (out_last) last_cyc = cyc;
      end
      stall_prev = out_valid && !out_ready;
      if (stall_prev) begin
        stall_snap = {out_valid, out_data, out_eol, out_last};
        chk("stall_in_ready", 64'(in_ready), 64'(0));
      end
      if (in_valid && in_ready) in_hs++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_pix(input int w, input int h);
    int  n;
    bit  stop;
    stop = 0;
    for (int r = 0; r < h && !stop; r++) begin
      for (int c = 0; c < w && !stop; c++) begin
        in_valid = 1'b1;
        in_data  = 8'(img[r][c]);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!in_ready && n < 4000 && !abort);
        if (abort) begin
          stop = 1;
        end else if (!in_ready) begin
          chk("in_timeout", 64'(in_ready), 64'(1));
          stop = 1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    forever begin
      wait (drv_go);
      drv_go = 0;
      drive_pix(drv_w, drv_h);
    end
  end

  task automatic fill(input int unsigned v);
    foreach (img[r, c]) img[r][c] = v;
  endtask

  // Reference: I(r,c) by inclusion-exclusion over the padded, binarised image.
  task automatic start_frame(input int w, input int h, input bit be, input int th);
    int unsigned p, up, left, ul;
    int pw, ph;
    pw = ((w + 7) / 8) * 8;
    ph = ((h + 7) / 8) * 8;
    exp_q.delete();
    for (int r = 0; r < ph; r++) begin
      for (int c = 0; c < pw; c++) begin
        p = (r < h && c < w) ? img[r][c] : 255;
        if (be) p = (p <= th) ? 0 : 255;
        up   = (r > 0) ? ii[r-1][c] : 0;
        left = (c > 0) ? ii[r][c-1] : 0;
        ul   = (r > 0 && c > 0) ? ii[r-1][c-1] : 0;
        ii[r][c] = p + up + left - ul;
        exp_q.push_back('{ii[r][c], (c == pw - 1), (r == ph - 1) && (c == pw - 1)});
      end
    end
    pw_cur = pw; br = 0; bc = 0; beats = 0; in_hs = 0; done_cnt = 0;
    img_w = 16'(w); img_h = 16'(h); bin_en = be; thr = 8'(th);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drv_w = w; drv_h = h; drv_go = 1;
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    chk({tag, "_done_lat"}, 64'(done_cyc), 64'(last_cyc + 1));
    chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_bits", 64'({out_data, out_eol, out_last}), 64'(0));
    chk("rst_flags", 64'({busy, done, cfg_err, in_ready}), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 8x8 of ones at full throughput
    fill(1);
    start_frame(8, 8, 0, 0);
    finish_frame("ones");
    chk("ones_beats", 64'(beats), 64'(64));
    chk("ones_in_hs", 64'(in_hs), 64'(64));
    chk("ones_00", 64'(got[0][0]), 64'(1));
    chk("ones_34", 64'(got[3][4]), 64'(20));
    chk("ones_77", 64'(got[7][7]), 64'(64));
    chk("ones_tput", 64'(last_cyc - first_cyc), 64'(63));

    // 5x3 zeros padded to 8x8 with 255
    fill(0);
    start_frame(5, 3, 0, 0);
    finish_frame("pad");
    chk("pad_beats", 64'(beats), 64'(64));
    chk("pad_in_hs", 64'(in_hs), 64'(15));
    chk("pad_07", 64'(got[0][7]), 64'(765));
    chk("pad_77", 64'(got[7][7]), 64'(12495));

    // binarisation at the threshold boundary
    fill(0);
    img[0][0] = 135;
    img[0][1] = 136;
    start_frame(8, 8, 1, 135);
    finish_frame("bin");
    chk("bin_00", 64'(got[0][0]), 64'(0));
    chk("bin_01", 64'(got[0][1]), 64'(255));
    chk("bin_07", 64'(got[0][7]), 64'(255));
    chk("bin_77", 64'(got[7][7]), 64'(255));

    // random backpressure
    fill(1);
    rand_ready = 1;
    start_frame(8, 8, 0, 0);
    finish_frame("rand");
    rand_ready = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rand_beats", 64'(beats), 64'(64));
    chk("rand_77", 64'(got[7][7]), 64'(64));

    // start pulse while running is ignored
    fill(1);
    start_frame(8, 8, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    img_w = 16'd3;
    img_h = 16'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_busy", 64'(busy), 64'(1));
    finish_frame("restart");
    chk("restart_beats", 64'(beats), 64'(64));
    chk("restart_77", 64'(got[7][7]), 64'(64));

    // reset mid-frame aborts, next frame is clean
    fill(1);
    start_frame(8, 8, 0, 0);
    n = 0;
    while (beats < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b0;
    abort = 1;
    repeat (3) @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    abort = 0;
    in_valid = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    @(posedge clk);
    #1;
    start_frame(8, 8, 0, 0);
    finish_frame("after_rst");
    chk("after_rst_beats", 64'(beats), 64'(64));
    chk("after_rst_00", 64'(got[0][0]), 64'(1));
    chk("after_rst_77", 64'(got[7][7]), 64'(64));

    // configuration errors
    img_w = 16'd1025;
    img_h = 16'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("cfg_w_err", 64'(cfg_err), 64'(1));
    chk("cfg_w_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    chk("cfg_w_pulse", 64'(cfg_err), 64'(0));
    chk("cfg_w_idle", 64'(busy), 64'(0));
    img_w = 16'd8;
    img_h = 16'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("cfg_h0_err", 64'(cfg_err), 64'(1));
    chk("cfg_h0_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
